// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight; result and optional flag update are held until consumed.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [2:0]  req0_cntrl,
  input  logic [2:0]  req1_cntrl,
  input  logic        req0_setf,
  input  logic        req1_setf,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_result,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [2:0]  alu_cntrl,
  input  logic [63:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_c,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;
  logic        setf_reg;
  logic        id_reg;
  logic [63:0] alu_a_reg, alu_b_reg, resp_result_reg;
  logic [2:0]  alu_cntrl_reg;
  logic        resp_id_reg;
  logic [3:0]  flags_reg;
  logic [1:0]  grant;
  logic        can_accept;
  logic        accept;
  logic        accept_id;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign can_accept = reset && ((state_reg == IDLE) || ((state_reg == RESP) && resp_ready));
  assign req_ready  = {2{can_accept}} & grant;
  assign accept     = |(req_valid & req_ready);
  assign accept_id  = req_valid[1] & req_ready[1];

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (state_reg == RESP);
    busy       = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_reg  <= 1'b1;
      setf_reg        <= 1'b0;
      id_reg          <= 1'b0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_cntrl_reg   <= '0;
      resp_result_reg <= '0;
      resp_id_reg     <= 1'b0;
      flags_reg       <= '0;
    end else begin
      if (accept) begin
        last_grant_reg <= accept_id;
        id_reg         <= accept_id;
        alu_a_reg      <= accept_id ? req1_a : req0_a;
        alu_b_reg      <= accept_id ? req1_b : req0_b;
        alu_cntrl_reg  <= accept_id ? req1_cntrl : req0_cntrl;
        setf_reg       <= accept_id ? req1_setf : req0_setf;
      end
      // The shared ALU is combinational, so its outputs are valid during EXEC.
      if (state_reg == EXEC) begin
        resp_result_reg <= alu_result;
        resp_id_reg     <= id_reg;
        if (setf_reg) flags_reg <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
      end
    end
  end

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_cntrl   = alu_cntrl_reg;
  assign resp_result = resp_result_reg;
  assign resp_id     = resp_id_reg;
  assign {flag_n, flag_z, flag_v, flag_c} = flags_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU sits on the shared port, and a
// scoreboard matches accepted requests against delivered responses.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_cntrl, req1_cntrl;
  logic        req0_setf, req1_setf;
  logic        resp_valid, resp_ready, resp_id;
  logic [63:0] resp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_cntrl;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        flag_n, flag_z, flag_v, flag_c, busy;

  typedef struct {
    logic        id;
    logic [63:0] result;
    int          cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t act_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   resp_start = 0;
  logic resp_pend = 1'b0;

  always #5 clk = ~clk;

  // Returns {N, Z, V, C, result}.
  function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] op);
    logic [64:0] s;
    logic [63:0] r;
    logic        v, c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0]; c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0]; c = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  logic [67:0] alu_bus;
  assign alu_bus = alu_model(alu_a, alu_b, alu_cntrl);
  assign alu_result = alu_bus[63:0];
  assign {alu_negative, alu_zero, alu_overflow, alu_carry_out} = alu_bus[67:64];

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_cntrl(req0_cntrl), .req1_cntrl(req1_cntrl),
    .req0_setf(req0_setf), .req1_setf(req1_setf),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
    .busy(busy)
  );

  // One clock: record acceptances and completed responses, then step to the next negedge.
  task automatic advance();
    txn_t t;
    logic id;
    #1;
    if (!reset) begin
      resp_pend = 1'b0;
    end else begin
      if ((req_valid & req_ready) != 2'b00) begin
        id = req_valid[1] & req_ready[1];
        t.id = id;
        t.result = id ? alu_model(req1_a, req1_b, req1_cntrl) : alu_model(req0_a, req0_b, req0_cntrl);
        t.cyc = cyc;
        exp_q.push_back(t);
      end
      if (resp_valid === 1'b1 && !resp_pend) begin
        resp_pend = 1'b1;
        resp_start = cyc;
      end
      if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
        t.id = resp_id;
        t.result = resp_result;
        t.cyc = resp_start;
        act_q.push_back(t);
        resp_pend = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
    req0_a = 64'd9; req0_b = 64'd9; req0_cntrl = 3'b010; req0_setf = 1'b1;
    req1_a = 64'd4; req1_b = 64'd4; req1_cntrl = 3'b011; req1_setf = 1'b1;
    advance();
    advance();
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_cntrl !== 3'b000) begin
      n_fail++; $display("FAIL reset_alu got=%0h/%0h/%b want=0/0/000", alu_a, alu_b, alu_cntrl);
    end
    n_checks++; if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000", {flag_n, flag_z, flag_v, flag_c});
    end
    n_checks++; if (resp_result !== 64'd0 || resp_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp got=%0h/%b want=0/0", resp_result, resp_id);
    end
    reset = 1'b1; req_valid = 2'b00;
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    txn_t e, a;
    req0_a = 64'd5; req0_b = 64'd7; req0_cntrl = 3'b010; req0_setf = 1'b1;
    req_valid = 2'b01; resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_req_ready got=%b want=01", req_ready); end
    advance();
    req_valid = 2'b00;
    n_checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_cntrl !== 3'b010) begin
      n_fail++; $display("FAIL add_alu_ops got=%0d/%0d/%b want=5/7/010", alu_a, alu_b, alu_cntrl);
    end
    n_checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_exec got busy=%b resp_valid=%b want 1/0", busy, resp_valid);
    end
    advance();
    n_checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 64'd12) begin
      n_fail++; $display("FAIL add_resp got v=%b id=%b res=%0d want 1/0/12", resp_valid, resp_id, resp_result);
    end
    n_checks++; if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
      n_fail++; $display("FAIL add_flags got=%b want=0000", {flag_n, flag_z, flag_v, flag_c});
    end
    advance();
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_idle got v=%b busy=%b want 0/0", resp_valid, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL add_sb_missing got=none want id=%b res=%0h", e.id, e.result); end
      else begin
        a = act_q.pop_front();
        if (a.id !== e.id || a.result !== e.result || a.cyc - e.cyc != 2) begin
          n_fail++; $display("FAIL add_sb got id=%b res=%0h lat=%0d want id=%b res=%0h lat=2", a.id, a.result, a.cyc - e.cyc, e.id, e.result);
        end
      end
    end
    $display("test_single_add done");
  endtask

  task automatic test_back_to_back();
    txn_t e, a;
    reset = 1'b0;
    advance();
    reset = 1'b1;
    exp_q.delete(); act_q.delete();
    req0_a = 64'd100; req0_b = 64'd1; req0_cntrl = 3'b010; req0_setf = 1'b0;
    req1_a = 64'd200; req1_b = 64'd2; req1_cntrl = 3'b011; req1_setf = 1'b0;
    req_valid = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) advance();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) advance();
    n_checks++; if (act_q.size() != 4) begin n_fail++; $display("FAIL b2b_count got=%0d want=4", act_q.size()); end
    for (int i = 0; i < act_q.size(); i++) begin
      n_checks++;
      if (act_q[i].id !== i[0]) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%b want=%b", i, act_q[i].id, i[0]); end
      if (i > 0) begin
        n_checks++;
        if (act_q[i].cyc - act_q[i-1].cyc != 2) begin
          n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d want=2", i, act_q[i].cyc - act_q[i-1].cyc);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb_missing got=none want id=%b res=%0h", e.id, e.result); end
      else begin
        a = act_q.pop_front();
        if (a.id !== e.id || a.result !== e.result || a.cyc - e.cyc != 2) begin
          n_fail++; $display("FAIL b2b_sb got id=%b res=%0h lat=%0d want id=%b res=%0h lat=2", a.id, a.result, a.cyc - e.cyc, e.id, e.result);
        end
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    txn_t e, a;
    req0_a = 64'd20; req0_b = 64'd22; req0_cntrl = 3'b010; req0_setf = 1'b0;
    req_valid = 2'b01; resp_ready = 1'b0;
    advance();
    req0_a = 64'd1; req0_b = 64'd2;
    advance();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== 64'd42 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b res=%0d id=%b rdy=%b want 1/42/0/00", i, resp_valid, resp_result, resp_id, req_ready);
      end
      advance();
    end
    resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_pulse_ready got=%b want=01", req_ready); end
    advance();
    resp_ready = 1'b0; req_valid = 2'b00;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_exec got v=%b busy=%b want 0/1", resp_valid, busy);
    end
    advance();
    n_checks++; if (resp_valid !== 1'b1 || resp_result !== 64'd3) begin
      n_fail++; $display("FAIL bp_second got v=%b res=%0d want 1/3", resp_valid, resp_result);
    end
    resp_ready = 1'b1;
    advance();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL bp_sb_missing got=none want id=%b res=%0h", e.id, e.result); end
      else begin
        a = act_q.pop_front();
        if (a.id !== e.id || a.result !== e.result || a.cyc - e.cyc != 2) begin
          n_fail++; $display("FAIL bp_sb got id=%b res=%0h lat=%0d want id=%b res=%0h lat=2", a.id, a.result, a.cyc - e.cyc, e.id, e.result);
        end
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_flags();
    txn_t e, a;
    req1_a = 64'd3; req1_b = 64'd3; req1_cntrl = 3'b011; req1_setf = 1'b1;
    req_valid = 2'b10; resp_ready = 1'b1;
    advance();
    req_valid = 2'b00;
    advance();
    n_checks++; if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101 || resp_result !== 64'd0 || resp_id !== 1'b1) begin
      n_fail++; $display("FAIL flags_sub got nzvc=%b res=%0h id=%b want 0101/0/1", {flag_n, flag_z, flag_v, flag_c}, resp_result, resp_id);
    end
    advance();
    req0_a = 64'h8000000000000000; req0_b = 64'h8000000000000000; req0_cntrl = 3'b010; req0_setf = 1'b0;
    req_valid = 2'b01;
    advance();
    req_valid = 2'b00;
    advance();
    n_checks++; if (resp_valid !== 1'b1 || resp_result !== 64'd0) begin
      n_fail++; $display("FAIL flags_nosetf_res got v=%b res=%0h want 1/0", resp_valid, resp_result);
    end
    n_checks++; if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
      n_fail++; $display("FAIL flags_hold got=%b want=0101", {flag_n, flag_z, flag_v, flag_c});
    end
    advance();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL flags_sb_missing got=none want id=%b res=%0h", e.id, e.result); end
      else begin
        a = act_q.pop_front();
        if (a.id !== e.id || a.result !== e.result || a.cyc - e.cyc != 2) begin
          n_fail++; $display("FAIL flags_sb got id=%b res=%0h lat=%0d want id=%b res=%0h lat=2", a.id, a.result, a.cyc - e.cyc, e.id, e.result);
        end
      end
    end
    $display("test_flags done");
  endtask

  task automatic test_reset_mid();
    txn_t e, a;
    req0_a = '1; req0_b = '1; req0_cntrl = 3'b100; req0_setf = 1'b1;
    req_valid = 2'b01; resp_ready = 1'b1;
    advance();
    req_valid = 2'b00;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_exec got busy=%b want=1", busy); end
    reset = 1'b0;
    advance();
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || {flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset got v=%b busy=%b nzvc=%b want 0/0/0000", resp_valid, busy, {flag_n, flag_z, flag_v, flag_c});
    end
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp cyc=%0d got=%b want=0", i, resp_valid); end
      advance();
    end
    n_checks++; if (act_q.size() != 0) begin n_fail++; $display("FAIL mid_discard got=%0d responses want=0", act_q.size()); end
    act_q.delete();
    req1_a = 64'd6; req1_b = 64'd9; req1_cntrl = 3'b000; req1_setf = 1'b0;
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_tie got=%b want=01", req_ready); end
    advance();
    req_valid = 2'b00;
    advance();
    advance();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL mid_sb_missing got=none want id=%b res=%0h", e.id, e.result); end
      else begin
        a = act_q.pop_front();
        if (a.id !== 1'b0 || a.id !== e.id || a.result !== e.result || a.cyc - e.cyc != 2) begin
          n_fail++; $display("FAIL mid_sb got id=%b res=%0h lat=%0d want id=0 res=%0h lat=2", a.id, a.result, a.cyc - e.cyc, e.result);
        end
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_flags();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
